// File: rtl/zrb_uart_rx.sv
// zrb_uart_rx: 8N1 UART receiver qualified by an OVERSAMPLE x baud strobe.
// Delivers each good byte with a one-cycle data_valid pulse. A low stop bit
// gives a one-cycle frame_err pulse instead.
// Optional build macro: ZRB_UART_RX_MAJORITY_EN. When it is defined, each
// start, data and stop decision is a 2-of-3 vote over the ticks around the
// bit centre. That vote resolves one sample_tick later than the
// single-sample default.
module zrb_uart_rx #(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE) + 1;
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam int HALF  = OVERSAMPLE / 2;
`ifdef ZRB_UART_RX_MAJORITY_EN
    localparam int LAG = 1;   // decision is taken one tick after the centre
`else
    localparam int LAG = 0;
`endif
    // Tick-counter values at which a decision is made. After a decision the
    // counter reloads to LAG, so the next centre stays one bit period away.
    localparam logic [CNT_W-1:0] START_DEC  = CNT_W'(HALF - 1 + LAG);
    localparam logic [CNT_W-1:0] BIT_DEC    = CNT_W'(OVERSAMPLE - 1 + LAG);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LAG);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       tick_cnt_reg, tick_cnt_next;
    logic [BIT_W-1:0]       bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic [DATA_BITS-1:0]   data_reg, data_next;
    logic                   valid_reg, valid_next;
    logic                   ferr_reg, ferr_next;
    logic                   armed_reg, armed_next;
    logic                   rx_meta, rx_s;
    logic [CNT_W-1:0]       dec_cnt;
    logic                   at_dec;
    logic                   bit_val;

    // Two-flop synchronizer. It resets high so that reset never looks like a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign dec_cnt = (state_reg == START) ? START_DEC : BIT_DEC;
    assign at_dec  = sample_tick && (tick_cnt_reg == dec_cnt);

`ifdef ZRB_UART_RX_MAJORITY_EN
    logic [1:0] vote_reg, vote_next;

    // Capture the centre-1 and centre samples. The centre+1 sample is rx_s itself.
    always_comb begin
        vote_next = vote_reg;
        if (sample_tick && state_reg != IDLE) begin
            if (tick_cnt_reg == dec_cnt - CNT_W'(2)) vote_next[0] = rx_s;
            if (tick_cnt_reg == dec_cnt - CNT_W'(1)) vote_next[1] = rx_s;
        end
    end

    // Vote sample register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vote_reg <= 2'b00;
        else          vote_reg <= vote_next;
    end

    assign bit_val = (vote_reg[0] & vote_reg[1]) | (vote_reg[0] & rx_s) |
                     (vote_reg[1] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    // Next-state logic: frame sequencing, bit assembly and output pulses.
    always_comb begin
        state_next    = state_reg;
        tick_cnt_next = tick_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        data_next     = data_reg;
        valid_next    = 1'b0;
        ferr_next     = 1'b0;
        armed_next    = armed_reg;
        case (state_reg)
            IDLE: begin
                if (sample_tick) begin
                    if (rx_s) begin
                        armed_next = 1'b1;     // the line was seen high, so a start edge is accepted
                    end else if (armed_reg) begin
                        state_next    = START;
                        tick_cnt_next = '0;
                    end
                end
            end
            START: begin
                if (at_dec) begin
                    if (bit_val) begin
                        state_next    = IDLE;  // false start: the glitch has gone by mid start bit
                        tick_cnt_next = '0;
                    end else begin
                        state_next    = DATA;
                        tick_cnt_next = CNT_RELOAD;
                        bit_cnt_next  = '0;
                    end
                end else if (sample_tick) begin
                    tick_cnt_next = tick_cnt_reg + CNT_W'(1);
                end
            end
            DATA: begin
                if (at_dec) begin
                    shift_next    = {bit_val, shift_reg[DATA_BITS-1:1]};
                    bit_cnt_next  = bit_cnt_reg + BIT_W'(1);
                    tick_cnt_next = CNT_RELOAD;
                    if (bit_cnt_reg == LAST_BIT) state_next = STOP;
                end else if (sample_tick) begin
                    tick_cnt_next = tick_cnt_reg + CNT_W'(1);
                end
            end
            STOP: begin
                if (at_dec) begin
                    if (bit_val) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                    end else begin
                        ferr_next  = 1'b1;
                        armed_next = 1'b0;     // a break must release before the next frame
                    end
                    state_next    = IDLE;
                    tick_cnt_next = '0;
                end else if (sample_tick) begin
                    tick_cnt_next = tick_cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            ferr_reg     <= 1'b0;
            armed_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tick_cnt_reg <= tick_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            data_reg     <= data_next;
            valid_reg    <= valid_next;
            ferr_reg     <= ferr_next;
            armed_reg    <= armed_next;
        end
    end

    assign data_out   = data_reg;
    assign data_valid = valid_reg;
    assign frame_err  = ferr_reg;
    assign busy       = (state_reg != IDLE);

endmodule
